icache_assoc: RTL and testbench
===============================

Name: icache_assoc

Overview:
- Parametrised set-associative instruction cache; successor to the fixed direct-mapped icache inside the caches wrapper.
- Sits between the datapath instruction-fetch port (imemREN/imemaddr/ihit/imemload) and the memory-controller instruction port (iREN/iaddr/iwait/iload).
- Generalises ways, sets and block size; adds true-LRU replacement, multi-word block fill and a flush.

Parameters:
- WAYS, 2, associativity; legal values 1, 2, 4.
- SETS, 8, sets per way; power of two, at least 2.
- WORDS, 2, 32-bit words per block; power of two, at least 1.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, synchronous, active-low.
- imemREN  in  1  fetch request.
- imemaddr  in  32  fetch byte address, word aligned.
- ihit  out  1  fetch data valid this cycle.
- imemload  out  32  fetched instruction.
- iflush  in  1  invalidate every line.
- iREN  out  1  memory read request.
- iaddr  out  32  memory read address.
- iwait  in  1  memory busy; data is valid when low while iREN is high.
- iload  in  32  memory read data.

Behaviour:
- Address split:
  - [1:0] byte offset, ignored.
  - Next log2(WORDS) bits: word offset.
  - Next log2(SETS) bits: index.
  - Remaining bits: tag.
- Storage per line: valid bit, tag and WORDS data words. Each set also holds a log2(WAYS)-bit age per way.
- Reset, applied on the first CLK edge with nRST low:
  - All valid bits cleared.
  - age[w] = w in every set.
  - State IDLE, fill counter 0.
  - Outputs ihit=0, iREN=0, iaddr=0, imemload=0.
- Hit: combinational, zero latency. In IDLE with imemREN=1 and a way valid with matching tag:
  - ihit=1.
  - imemload = the selected word of that way.
  - LRU update at the clock edge: the hit way's age becomes 0; every way whose age was below the hit way's old age increments by 1.
- imemload is 0 whenever ihit=0.
- States are IDLE and FILL.
- IDLE to FILL: imemREN=1, no hit, iflush=0.
  - Latch the block base address (word offset zeroed).
  - Select the victim: the lowest-numbered invalid way, otherwise the way with age WAYS-1.
  - fill counter = 0.
- FILL:
  - iREN=1; iaddr = base + 4*counter.
  - On each cycle with iwait=0, write iload into victim word[counter] and increment the counter.
  - When the word at counter WORDS-1 is accepted, in the same edge: set the victim's valid bit and tag, apply the LRU update with the victim as the accessed way, and go to IDLE.
- Miss latency: WORDS accepted transfers, then the hit is reported in the following IDLE cycle if the request is still present.
- ihit is 0 throughout FILL.
- Changes to imemaddr or imemREN during FILL are ignored. The fill always completes and installs the latched block. The request is re-evaluated in IDLE.
- iflush=1 in any state:
  - Next edge clears all valid bits and resets ages as at reset.
  - State goes to IDLE and any in-progress fill is discarded.
  - ihit is forced to 0 in that cycle.
- Reset mid-fill: the fill is abandoned and iREN=0 from the next cycle.
- WAYS=1: age storage is absent; the victim is always way 0.
- The hit path must not depend on iwait or iload.

Optional Feature:
- ICACHE_STATS_EN.
- Defined: adds outputs hit_count (32, out) and miss_count (32, out).
  - hit_count increments on each cycle with ihit=1.
  - miss_count increments on each IDLE-to-FILL transition.
  - Both wrap at 2^32 and are cleared by reset and by iflush.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- cpu_types_pkg gains:
  - icache_state_t (IDLE, FILL).
  - Address-field width constants derived from the parameters, supplied as functions taking WAYS/SETS/WORDS.
- One sub-module, icache_lru: per-set age array with an access/update port and a victim output, instantiated once.

Test Plan (WAYS=2, SETS=8, WORDS=2):
- Cold miss:
  - Stimulus: read 0x40 (index 0, tag 1); memory holds 0xAAAA0001 at 0x40 and 0xAAAA0002 at 0x44; iwait held high 2 cycles per word.
  - Response: iaddr 0x40 then 0x44; ihit=0 during the fill, then ihit=1 with imemload=0xAAAA0001.
  - Follow-up: read 0x44 hits in the same cycle with 0xAAAA0002 and iREN=0.
- Conflict:
  - Stimulus: fill 0x40, then 0x80, then 0xC0 (all index 0).
  - Response: 0xC0 evicts 0x40; a re-read of 0x80 hits; a re-read of 0x40 misses.
- LRU refresh:
  - Stimulus: fill 0x40 and 0x80, hit 0x40, then read 0xC0.
  - Response: 0x80 is evicted; 0x40 still hits.
- Reset mid-fill:
  - Stimulus: pull nRST low after the first word of 0x40 is accepted.
  - Response: iREN=0 on the next cycle; after reset, 0x40 misses and refills both words.
- Flush:
  - Stimulus: after 0x40 is cached, pulse iflush for 1 cycle while reading 0x40.
  - Response: ihit=0 in the flush cycle; the next read of 0x40 misses.
  - Also: iflush during a fill aborts the fill to IDLE.
- Stats (ICACHE_STATS_EN defined):
  - Stimulus: the cold-miss scenario plus 3 hits.
  - Response: miss_count=1, hit_count=4 (the post-fill hit plus 3); both 0 after iflush.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction-cache FSM state and address-field widths.
// Consumed by icache_assoc (optional ICACHE_STATS_EN counters) and icache_lru.
package cpu_types_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } icache_state_t;

   function automatic int ic_way_bits(int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

   // True word-offset width; zero for single-word blocks.
   function automatic int ic_off_bits(int words);
      return $clog2(words);
   endfunction

   function automatic int ic_cnt_bits(int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

   function automatic int ic_idx_bits(int sets);
      return $clog2(sets);
   endfunction

   function automatic int ic_tag_bits(int sets, int words);
      return 30 - $clog2(sets) - $clog2(words);
   endfunction

endpackage

// File: rtl/icache_assoc_if.sv
// Fetch-side and memory-side signals of the instruction cache.
interface icache_assoc_if;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iflush;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;

   modport slave (
      input  imemREN, imemaddr, iflush, iwait, iload,
      output ihit, imemload, iREN, iaddr
   );

   modport master (
      output imemREN, imemaddr, iflush, iwait, iload,
      input  ihit, imemload, iREN, iaddr
   );
endinterface

// File: rtl/icache_lru.sv
// True-LRU age array: one age per way per set, age WAYS-1 is the victim.
module icache_lru
   import cpu_types_pkg::*;
#(
   parameter int WAYS = 2,
   parameter int SETS = 8,
   localparam int WB = ic_way_bits(WAYS),
   localparam int IB = ic_idx_bits(SETS)
) (
   input  logic          CLK,
   input  logic          i_clr,
   input  logic          i_upd,
   input  logic [IB-1:0] i_set,
   input  logic [WB-1:0] i_way,
   input  logic [IB-1:0] i_vset,
   output logic [WB-1:0] o_victim
);

   if (WAYS == 1) begin : g_one
      wire w_unused = ^{CLK, i_clr, i_upd, i_set, i_way, i_vset};
      assign o_victim = '0;
   end else begin : g_age
      logic [WB-1:0] r_age [SETS][WAYS];

      always_ff @(posedge CLK) begin
         if (i_clr) begin
            for (int s = 0; s < SETS; s++)
               for (int w = 0; w < WAYS; w++)
                  r_age[s][w] <= WB'(w);
         end else if (i_upd) begin
            for (int w = 0; w < WAYS; w++) begin
               if (WB'(w) == i_way)
                  r_age[i_set][w] <= '0;
               else if (r_age[i_set][w] < r_age[i_set][i_way])
                  r_age[i_set][w] <= r_age[i_set][w] + 1'b1;
            end
         end
      end

      always_comb begin
         o_victim = '0;
         for (int w = 0; w < WAYS; w++)
            if (r_age[i_vset][w] == WB'(WAYS - 1))
               o_victim = WB'(w);
      end
   end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative I-cache with true-LRU, multi-word fill and flush.
// ICACHE_STATS_EN adds hit_count/miss_count outputs.
module icache_assoc
   import cpu_types_pkg::*;
#(
   parameter int WAYS  = 2,
   parameter int SETS  = 8,
   parameter int WORDS = 2
) (
   input logic            CLK,
   input logic            nRST,
   icache_assoc_if.slave  bus
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]    hit_count,
   output logic [31:0]    miss_count
`endif
);

   localparam int WB = ic_way_bits(WAYS);
   localparam int OB = ic_off_bits(WORDS);
   localparam int CB = ic_cnt_bits(WORDS);
   localparam int IB = ic_idx_bits(SETS);
   localparam int TB = ic_tag_bits(SETS, WORDS);

   icache_state_t r_state;
   logic          r_iren;
   logic [31:0]   r_iaddr;
   logic [CB-1:0] r_cnt;
   logic [WB-1:0] r_victim;
   logic [IB-1:0] r_fidx;
   logic [TB-1:0] r_ftag;
   logic          r_valid [WAYS][SETS];
   logic [TB-1:0] r_tag   [WAYS][SETS];
   logic [31:0]   r_data  [WAYS][SETS][WORDS];

   logic [CB-1:0] w_woff;
   logic [IB-1:0] w_idx;
   logic [TB-1:0] w_tag;
   logic          w_match;
   logic [WB-1:0] w_hway;
   logic [WB-1:0] w_lru_victim;
   logic [WB-1:0] w_victim;
   logic          w_clr, w_ihit, w_miss, w_acc, w_last, w_done;

   wire w_unused = ^bus.imemaddr[1:0];

   if (WORDS > 1) begin : g_off
      assign w_woff = bus.imemaddr[2 +: CB];
   end else begin : g_noff
      assign w_woff = '0;
   end

   assign w_idx  = bus.imemaddr[2 + OB +: IB];
   assign w_tag  = bus.imemaddr[31 -: TB];
   assign w_clr  = !nRST || bus.iflush;
   assign w_acc  = (r_state == FILL) && !bus.iwait;
   assign w_last = w_acc && (r_cnt == CB'(WORDS - 1));
   assign w_done = w_last && !w_clr;
   assign w_miss = (r_state == IDLE) && bus.imemREN && !w_match;

   always_comb begin
      w_match = 1'b0;
      w_hway  = '0;
      for (int w = 0; w < WAYS; w++)
         if (r_valid[w][w_idx] && r_tag[w][w_idx] == w_tag) begin
            w_match = 1'b1;
            w_hway  = WB'(w);
         end
   end

   // Invalid ways are filled first, lowest number wins.
   always_comb begin
      w_victim = w_lru_victim;
      for (int w = WAYS - 1; w >= 0; w--)
         if (!r_valid[w][w_idx])
            w_victim = WB'(w);
   end

   assign w_ihit = (r_state == IDLE) && bus.imemREN
                && w_match && !bus.iflush;

   assign bus.ihit     = w_ihit;
   assign bus.imemload = w_ihit ? r_data[w_hway][w_idx][w_woff] : '0;
   assign bus.iREN     = r_iren;
   assign bus.iaddr    = r_iaddr;

   icache_lru #(
      .WAYS (WAYS),
      .SETS (SETS)
   ) u_lru (
      .CLK      (CLK),
      .i_clr    (w_clr),
      .i_upd    (w_ihit || w_done),
      .i_set    (w_ihit ? w_idx : r_fidx),
      .i_way    (w_ihit ? w_hway : r_victim),
      .i_vset   (w_idx),
      .o_victim (w_lru_victim)
   );

   always_ff @(posedge CLK) begin
      if (w_clr) begin
         r_state <= IDLE;
         r_iren  <= 1'b0;
         r_iaddr <= '0;
         r_cnt   <= '0;
      end else begin
         unique case (r_state)
            IDLE: if (w_miss) begin
               r_state  <= FILL;
               r_iren   <= 1'b1;
               r_iaddr  <= bus.imemaddr & ~32'(WORDS * 4 - 1);
               r_cnt    <= '0;
               r_victim <= w_victim;
               r_fidx   <= w_idx;
               r_ftag   <= w_tag;
            end
            FILL: if (w_acc) begin
               r_cnt   <= r_cnt + 1'b1;
               r_iaddr <= r_iaddr + 32'd4;
               if (w_last) begin
                  r_state <= IDLE;
                  r_iren  <= 1'b0;
                  r_iaddr <= '0;
                  r_cnt   <= '0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (w_clr) begin
         for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++)
               r_valid[w][s] <= 1'b0;
      end else if (w_done) begin
         r_valid[r_victim][r_fidx] <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (w_acc)
         r_data[r_victim][r_fidx][r_cnt] <= bus.iload;
      if (w_done)
         r_tag[r_victim][r_fidx] <= r_ftag;
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge CLK) begin
      if (w_clr) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (w_ihit)
            hit_count <= hit_count + 32'd1;
         if (w_miss)
            miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Scoreboard bench for icache_assoc (WAYS=2, SETS=8, WORDS=2).
module tb_icache_assoc;

   localparam int MISS = 7;

   logic CLK = 1'b0;
   logic nRST = 1'b0;
   always #5 CLK = ~CLK;

   icache_assoc_if bus();

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   icache_assoc #(
      .WAYS  (2),
      .SETS  (8),
      .WORDS (2)
   ) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
`ifdef ICACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   int n_chk = 0;
   int n_err = 0;
   int wc = 0;
   logic [31:0] exp_q [$];
   logic [31:0] addr_log [$];

   function automatic logic [31:0] mem_word(logic [31:0] a);
      return 32'hAAAA0000 + (a >> 2) - 32'd15;
   endfunction

   // Memory: two busy cycles, then one ready cycle per word.
   assign bus.iload = mem_word(bus.iaddr);
   assign bus.iwait = (wc != 2);

   always @(posedge CLK)
      if (!bus.iREN) wc <= 0;
      else wc <= (wc == 2) ? 0 : wc + 1;

   always @(negedge CLK)
      if (bus.iREN && !bus.iwait)
         addr_log.push_back(bus.iaddr);

   task automatic check(string tag, logic [31:0] act,
                        logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge CLK); #1;
      nRST = 1'b0;
      bus.imemREN = 1'b0;
      bus.iflush = 1'b0;
      bus.imemaddr = '0;
      repeat (2) @(posedge CLK);
      #1 nRST = 1'b1;
      addr_log.delete();
   endtask

   task automatic read(logic [31:0] a, int exp_lat);
      int lat = 0;
      bit got = 0;
      @(posedge CLK); #1;
      bus.imemaddr = a;
      bus.imemREN = 1'b1;
      exp_q.push_back(mem_word(a));
      while (!got && lat < 60) begin
         @(negedge CLK);
         if (bus.ihit) got = 1;
         else lat++;
      end
      if (got) begin
         check("data", bus.imemload, exp_q.pop_front());
         check("lat", 32'(lat), 32'(exp_lat));
         if (exp_lat == 0)
            check("iren_hit", 32'(bus.iREN), 32'd0);
      end else begin
         check("timeout", 32'd0, 32'd1);
         void'(exp_q.pop_front());
      end
      @(posedge CLK); #1;
      bus.imemREN = 1'b0;
   endtask

   task automatic check_fill(string tag, logic [31:0] base);
      check({tag, "_n"}, 32'(addr_log.size()), 32'd2);
      if (addr_log.size() == 2) begin
         check({tag, "_a0"}, addr_log[0], base);
         check({tag, "_a1"}, addr_log[1], base + 32'd4);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: sim time exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.imemREN = 1'b0;
      bus.iflush = 1'b0;
      bus.imemaddr = '0;

      // reset state and cold miss
      do_reset();
      @(negedge CLK);
      check("rst_ihit", 32'(bus.ihit), 32'd0);
      check("rst_iren", 32'(bus.iREN), 32'd0);
      check("rst_iaddr", bus.iaddr, 32'd0);
      check("rst_load", bus.imemload, 32'd0);
      read(32'h40, MISS);
      check_fill("cold", 32'h40);
      read(32'h44, 0);

      // conflict eviction
      do_reset();
      read(32'h40, MISS);
      read(32'h80, MISS);
      read(32'hC0, MISS);
      read(32'h80, 0);
      read(32'h40, MISS);

      // LRU refresh on hit
      do_reset();
      read(32'h40, MISS);
      read(32'h80, MISS);
      read(32'h40, 0);
      read(32'hC0, MISS);
      read(32'h40, 0);
      read(32'h80, MISS);

      // reset after first fill word
      do_reset();
      @(posedge CLK); #1;
      bus.imemaddr = 32'h40;
      bus.imemREN = 1'b1;
      for (int t = 0; t < 40 && addr_log.size() < 1; t++)
         @(negedge CLK);
      check("mf_acc", 32'(addr_log.size()), 32'd1);
      @(posedge CLK); #1;
      nRST = 1'b0;
      bus.imemREN = 1'b0;
      @(posedge CLK); #1;
      check("mf_iren", 32'(bus.iREN), 32'd0);
      nRST = 1'b1;
      addr_log.delete();
      read(32'h40, MISS);
      check_fill("mf", 32'h40);

      // flush while hitting
      do_reset();
      read(32'h40, MISS);
      @(posedge CLK); #1;
      bus.imemaddr = 32'h40;
      bus.imemREN = 1'b1;
      bus.iflush = 1'b1;
      @(negedge CLK);
      check("fl_ihit", 32'(bus.ihit), 32'd0);
      check("fl_load", bus.imemload, 32'd0);
      @(posedge CLK); #1;
      bus.iflush = 1'b0;
      bus.imemREN = 1'b0;
      read(32'h40, MISS);

      // flush during fill
      addr_log.delete();
      @(posedge CLK); #1;
      bus.imemaddr = 32'h80;
      bus.imemREN = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      bus.iflush = 1'b1;
      bus.imemREN = 1'b0;
      @(posedge CLK); #1;
      bus.iflush = 1'b0;
      check("ff_iren", 32'(bus.iREN), 32'd0);
      addr_log.delete();
      read(32'h80, MISS);
      check_fill("ff", 32'h80);

`ifdef ICACHE_STATS_EN
      do_reset();
      check("st_rst_h", hit_count, 32'd0);
      check("st_rst_m", miss_count, 32'd0);
      read(32'h40, MISS);
      read(32'h40, 0);
      read(32'h44, 0);
      read(32'h40, 0);
      check("st_miss", miss_count, 32'd1);
      check("st_hit", hit_count, 32'd4);
      @(posedge CLK); #1 bus.iflush = 1'b1;
      @(posedge CLK); #1 bus.iflush = 1'b0;
      check("st_fl_h", hit_count, 32'd0);
      check("st_fl_m", miss_count, 32'd0);
`endif

      check("q_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
